// File: rtl/tswitch_pkg.sv
// Shared tiny-switch types and widths.
package tswitch_pkg;

  localparam int ADDR_WIDTH    = 32;
  localparam int DATA_WIDTH    = 32;
  localparam int GROUP_ID_BITS = 4;

  // Multicast fan-out engine control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    SEND = 2'd3
  } mc_fanout_state_t;

endpackage

// File: rtl/prio_enc_lsb.sv
// Lowest-set-bit priority encoder: index and one-hot of the least significant 1.
module prio_enc_lsb #(
  parameter int W = 4,
  localparam int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic [W-1:0]  onehot
);

  // Scan from the top down so the lowest set bit wins; isolate it with two's complement.
  always_comb begin
    idx    = '0;
    onehot = vec & (~vec + W'(1));
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/mc_fanout.sv
// Multicast fan-out engine: looks up a command's group, then emits one beat
// per member port, lowest port first.
module mc_fanout
  import tswitch_pkg::*;
#(
  parameter int NUM_PORTS   = 4,
  parameter bit EXCLUDE_SRC = 1'b1,
  localparam int PW = $clog2(NUM_PORTS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ADDR_WIDTH-1:0]    cmd_addr,
  input  logic [DATA_WIDTH-1:0]    cmd_data,
  input  logic [PW-1:0]            cmd_src,
  output logic                     lk_valid,
  output logic [ADDR_WIDTH-1:0]    lk_addr,
  input  logic                     lk_ready,
  input  logic                     lk_result_valid,
  input  logic [NUM_PORTS-1:0]     lk_member_mask,
  input  logic [GROUP_ID_BITS-1:0] lk_group_id,
  input  logic                     lk_is_mc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PW-1:0]            out_port,
  output logic [ADDR_WIDTH-1:0]    out_addr,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic [GROUP_ID_BITS-1:0] out_group_id,
  output logic                     out_mc,
  output logic                     out_last,
  output logic                     done,
  output logic                     drop
);

  mc_fanout_state_t           state;
  logic [ADDR_WIDTH-1:0]      addr_q;
  logic [DATA_WIDTH-1:0]      data_q;
  logic [PW-1:0]              src_q;
  logic [NUM_PORTS-1:0]       mask_q;
  logic [GROUP_ID_BITS-1:0]   gid_q;
  logic                       mc_q;

  logic [NUM_PORTS-1:0]       src_onehot;
  logic [NUM_PORTS-1:0]       eff_mask;
  logic [PW-1:0]              low_idx;
  logic [NUM_PORTS-1:0]       low_onehot;
  logic                       one_left;

  prio_enc_lsb #(.W(NUM_PORTS)) u_enc (
    .vec    (mask_q),
    .idx    (low_idx),
    .onehot (low_onehot)
  );

  // Member mask after optionally removing the originating port; exactly-one-bit test for out_last.
  always_comb begin
    src_onehot = EXCLUDE_SRC ? (NUM_PORTS'(1) << src_q) : '0;
    eff_mask   = lk_member_mask & ~src_onehot;
    one_left   = (mask_q != '0) && ((mask_q & (mask_q - NUM_PORTS'(1))) == '0);
  end

  assign cmd_ready    = (state == IDLE);
  assign lk_valid     = (state == REQ);
  assign lk_addr      = addr_q;
  assign out_valid    = (state == SEND);
  assign out_port     = low_idx;
  assign out_addr     = addr_q;
  assign out_data     = data_q;
  assign out_group_id = gid_q;
  assign out_mc       = mc_q;
  assign out_last     = (state == SEND) && one_left;

  // Control FSM: accept, look up, capture the one-shot result, then drain the mask one port per handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      src_q  <= '0;
      mask_q <= '0;
      gid_q  <= '0;
      mc_q   <= 1'b0;
      done   <= 1'b0;
      drop   <= 1'b0;
    end else begin
      done <= 1'b0;
      drop <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            addr_q <= cmd_addr;
            data_q <= cmd_data;
            src_q  <= cmd_src;
            state  <= REQ;
          end
        end
        REQ: begin
          if (lk_ready) state <= WAIT;
        end
        WAIT: begin
          // The table presents its result for this single cycle only.
          if (lk_result_valid) begin
            mask_q <= eff_mask;
            gid_q  <= lk_group_id;
            mc_q   <= lk_is_mc;
            if (eff_mask == '0) begin
              drop  <= 1'b1;
              state <= IDLE;
            end else begin
              state <= SEND;
            end
          end
        end
        SEND: begin
          if (out_ready) begin
            mask_q <= mask_q & ~low_onehot;
            if (one_left) begin
              done  <= 1'b1;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_fanout.sv
// Directed bench for mc_fanout with a behavioural group table.
module tb_mc_fanout;
  import tswitch_pkg::*;

  localparam int NP = 4;
  localparam int PW = 2;

  logic                     clk;
  logic                     rst_n;
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [ADDR_WIDTH-1:0]    cmd_addr;
  logic [DATA_WIDTH-1:0]    cmd_data;
  logic [PW-1:0]            cmd_src;
  logic                     lk_valid;
  logic [ADDR_WIDTH-1:0]    lk_addr;
  logic                     lk_ready;
  logic                     lk_result_valid;
  logic [NP-1:0]            lk_member_mask;
  logic [GROUP_ID_BITS-1:0] lk_group_id;
  logic                     lk_is_mc;
  logic                     out_valid;
  logic                     out_ready;
  logic [PW-1:0]            out_port;
  logic [ADDR_WIDTH-1:0]    out_addr;
  logic [DATA_WIDTH-1:0]    out_data;
  logic [GROUP_ID_BITS-1:0] out_group_id;
  logic                     out_mc;
  logic                     out_last;
  logic                     done;
  logic                     drop;

  int total = 0;
  int bad   = 0;

  mc_fanout #(.NUM_PORTS(NP), .EXCLUDE_SRC(1'b1)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_addr        (cmd_addr),
    .cmd_data        (cmd_data),
    .cmd_src         (cmd_src),
    .lk_valid        (lk_valid),
    .lk_addr         (lk_addr),
    .lk_ready        (lk_ready),
    .lk_result_valid (lk_result_valid),
    .lk_member_mask  (lk_member_mask),
    .lk_group_id     (lk_group_id),
    .lk_is_mc        (lk_is_mc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_port        (out_port),
    .out_addr        (out_addr),
    .out_data        (out_data),
    .out_group_id    (out_group_id),
    .out_mc          (out_mc),
    .out_last        (out_last),
    .done            (done),
    .drop            (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Default group table, keyed on the top address nibble.
  task automatic table_lookup(input logic [31:0] a, output logic [3:0] m,
                              output logic [3:0] g, output logic mc);
    case (a[31:28])
      4'h1:    begin m = 4'b1111; g = 4'd0; mc = 1'b1; end
      4'h2:    begin m = 4'b0011; g = 4'd1; mc = 1'b1; end
      4'h3:    begin m = 4'b1100; g = 4'd2; mc = 1'b1; end
      default: begin m = 4'b0001; g = 4'd0; mc = 1'b0; end
    endcase
  endtask

  // One clock: sample the lookup handshake before the edge, answer one cycle after it.
  // Outside the strobe the table drives junk so a capture without the strobe shows up.
  task automatic tick();
    logic        hs;
    logic [31:0] a;
    hs = lk_valid && lk_ready;
    a  = lk_addr;
    @(posedge clk);
    #1;
    lk_result_valid = hs;
    if (hs) table_lookup(a, lk_member_mask, lk_group_id, lk_is_mc);
    else begin
      lk_member_mask = 4'b1111;
      lk_group_id    = 4'hF;
      lk_is_mc       = 1'b1;
    end
  endtask

  // Offer a command in cycle T; returns in T+1 with cmd_valid dropped.
  task automatic send_cmd(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_src   = s;
    check("acc_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    check("req_lk_valid", lk_valid, 1);
    check("req_lk_addr", lk_addr, a);
    check("req_cmd_ready", cmd_ready, 0);
  endtask

  task automatic beat_chk(input logic [1:0] p, input logic l, input logic [3:0] g,
                          input logic mc, input logic [31:0] a, input logic [31:0] d);
    check("beat_valid", out_valid, 1);
    check("beat_port", out_port, p);
    check("beat_last", out_last, l);
    check("beat_gid", out_group_id, g);
    check("beat_mc", out_mc, mc);
    check("beat_addr", out_addr, a);
    check("beat_data", out_data, d);
    check("beat_done", done, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0; cmd_src = '0;
    lk_ready = 1'b1; lk_result_valid = 1'b0; lk_member_mask = '0; lk_group_id = '0;
    lk_is_mc = 1'b0; out_ready = 1'b1;
    #1;
    check("rst_lk_valid", lk_valid, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_done", done, 0);
    check("rst_drop", drop, 0);
    check("rst_out_addr", out_addr, 0);
    check("rst_gid", out_group_id, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    check("rst_cmd_ready", cmd_ready, 1);
    tick();

    // Three-member fan-out with source port 2 excluded.
    send_cmd(32'h1000_0040, 32'hD1D1_0001, 2'd2);
    tick();
    check("t1_ov_t2", out_valid, 0);
    tick();
    beat_chk(2'd0, 1'b0, 4'd0, 1'b1, 32'h1000_0040, 32'hD1D1_0001); tick();
    beat_chk(2'd1, 1'b0, 4'd0, 1'b1, 32'h1000_0040, 32'hD1D1_0001); tick();
    beat_chk(2'd3, 1'b1, 4'd0, 1'b1, 32'h1000_0040, 32'hD1D1_0001); tick();
    check("t1_done", done, 1);
    check("t1_ready", cmd_ready, 1);
    check("t1_ov_end", out_valid, 0);
    tick();
    check("t1_done_clr", done, 0);

    // Back-pressure: each beat stalled one cycle.
    send_cmd(32'h3000_0000, 32'hD2D2_0002, 2'd0);
    tick(); tick();
    out_ready = 1'b0;
    beat_chk(2'd2, 1'b0, 4'd2, 1'b1, 32'h3000_0000, 32'hD2D2_0002); tick();
    beat_chk(2'd2, 1'b0, 4'd2, 1'b1, 32'h3000_0000, 32'hD2D2_0002);
    out_ready = 1'b1; tick();
    beat_chk(2'd3, 1'b1, 4'd2, 1'b1, 32'h3000_0000, 32'hD2D2_0002);
    out_ready = 1'b0; tick();
    beat_chk(2'd3, 1'b1, 4'd2, 1'b1, 32'h3000_0000, 32'hD2D2_0002);
    out_ready = 1'b1; tick();
    check("t2_done", done, 1);
    check("t2_ov_end", out_valid, 0);
    tick();

    // Single member after exclusion.
    send_cmd(32'h2000_0000, 32'hD3D3_0003, 2'd0);
    tick(); tick();
    beat_chk(2'd1, 1'b1, 4'd1, 1'b1, 32'h2000_0000, 32'hD3D3_0003); tick();
    check("t3_done", done, 1);
    tick();

    // Non-multicast address whose only port is the source: dropped.
    send_cmd(32'h0000_1000, 32'hD4D4_0004, 2'd0);
    tick();
    check("t4_drop_early", drop, 0);
    tick();
    check("t4_drop", drop, 1);
    check("t4_ready", cmd_ready, 1);
    check("t4_ov", out_valid, 0);
    check("t4_done", done, 0);
    tick();
    check("t4_drop_clr", drop, 0);
    check("t4_ov2", out_valid, 0);

    // Asynchronous reset in the middle of SEND.
    send_cmd(32'h1000_0000, 32'hD5D5_0005, 2'd1);
    tick(); tick();
    beat_chk(2'd0, 1'b0, 4'd0, 1'b1, 32'h1000_0000, 32'hD5D5_0005); tick();
    beat_chk(2'd2, 1'b0, 4'd0, 1'b1, 32'h1000_0000, 32'hD5D5_0005);
    #2 rst_n = 1'b0;
    #1;
    check("ar_ov", out_valid, 0);
    check("ar_last", out_last, 0);
    check("ar_lk_valid", lk_valid, 0);
    check("ar_ready", cmd_ready, 1);
    check("ar_port", out_port, 0);
    check("ar_addr", out_addr, 0);
    check("ar_data", out_data, 0);
    tick();
    check("ar_done", done, 0);
    check("ar_drop", drop, 0);
    rst_n = 1'b1;
    tick();
    check("ar_done2", done, 0);
    check("ar_ready2", cmd_ready, 1);
    send_cmd(32'h1000_0000, 32'hD6D6_0006, 2'd3);
    tick(); tick();
    beat_chk(2'd0, 1'b0, 4'd0, 1'b1, 32'h1000_0000, 32'hD6D6_0006); tick();
    beat_chk(2'd1, 1'b0, 4'd0, 1'b1, 32'h1000_0000, 32'hD6D6_0006); tick();
    beat_chk(2'd2, 1'b1, 4'd0, 1'b1, 32'h1000_0000, 32'hD6D6_0006); tick();
    check("t5_done", done, 1);
    tick();

    // Two queued commands with the table stalling for three cycles.
    lk_ready = 1'b0;
    send_cmd(32'h2000_0000, 32'hD7D7_0007, 2'd0);
    cmd_valid = 1'b1;
    cmd_addr  = 32'h3000_0000;
    cmd_data  = 32'hD8D8_0008;
    cmd_src   = 2'd0;
    tick();
    check("q_lk_valid1", lk_valid, 1);
    check("q_lk_addr1", lk_addr, 32'h2000_0000);
    check("q_ready1", cmd_ready, 0);
    tick();
    check("q_lk_valid2", lk_valid, 1);
    check("q_lk_addr2", lk_addr, 32'h2000_0000);
    check("q_ready2", cmd_ready, 0);
    lk_ready = 1'b1;
    tick();
    check("q_lk_valid3", lk_valid, 0);
    check("q_ready3", cmd_ready, 0);
    tick();
    beat_chk(2'd1, 1'b1, 4'd1, 1'b1, 32'h2000_0000, 32'hD7D7_0007);
    check("q_ready4", cmd_ready, 0);
    tick();
    check("q_done", done, 1);
    check("q_ready5", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    check("q2_done_clr", done, 0);
    check("q2_lk_valid", lk_valid, 1);
    check("q2_lk_addr", lk_addr, 32'h3000_0000);
    tick(); tick();
    beat_chk(2'd2, 1'b0, 4'd2, 1'b1, 32'h3000_0000, 32'hD8D8_0008); tick();
    beat_chk(2'd3, 1'b1, 4'd2, 1'b1, 32'h3000_0000, 32'hD8D8_0008); tick();
    check("q2_done", done, 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_fanout.md
# mc_fanout

Multicast fan-out engine for tiny-switch; the initiator side of the group-table lookup interface. Accepts one STORE_MC or LOAD_REDUCE command at a time and issues a lookup on its address. It captures the one-cycle member-mask result, optionally removes the source port, then emits one per-port beat for each remaining member, lowest port first. It sits between the ingress command decoder and the per-port egress arbiters.

## Interface
- NUM_PORTS, 4, switch ports (≥2, power of 2)
- EXCLUDE_SRC, 1, when 1 the source port is cleared from the member mask
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_addr  in  ADDR_WIDTH  multicast address
- cmd_data  in  DATA_WIDTH  payload
- cmd_src  in  $clog2(NUM_PORTS)  originating port
- lk_valid  out  1  lookup request
- lk_addr  out  ADDR_WIDTH  latched cmd_addr
- lk_ready  in  1  group table can accept
- lk_result_valid  in  1  one-cycle result strobe
- lk_member_mask  in  NUM_PORTS  participating ports
- lk_group_id  in  GROUP_ID_BITS  matched group
- lk_is_mc  in  1  address hit a group
- out_valid  out  1  beat valid
- out_ready  in  1  egress accepts beat
- out_port  out  $clog2(NUM_PORTS)  destination port
- out_addr / out_data  out  ADDR_WIDTH / DATA_WIDTH  latched command
- out_group_id  out  GROUP_ID_BITS  latched group id
- out_mc  out  1  latched lk_is_mc
- out_last  out  1  final beat of this command
- done  out  1  one-cycle pulse: command fully delivered
- drop  out  1  one-cycle pulse: effective mask empty, nothing sent

## Operation
- FSM states: IDLE, REQ, WAIT, SEND.
- IDLE: cmd_ready=1. On cmd_valid, latch addr, data and src, then go to REQ.
- REQ: lk_valid=1 and lk_addr=latched addr. On lk_ready, go to WAIT.
- WAIT: on lk_result_valid, capture the result.
  - eff_mask = lk_member_mask & ~(EXCLUDE_SRC ? onehot(src) : 0); also latch group_id and is_mc.
  - eff_mask==0: pulse drop next cycle and go to IDLE. Otherwise go to SEND.
  - lk_result_valid is the only capture point. The result is not held by the table.
- SEND: out_valid=1 and out_port = index of the lowest set bit of remaining mask.
  - out_last=1 when exactly one bit remains.
  - On out_valid&out_ready, clear that bit. On the last beat, go to IDLE and pulse done.
- All out_* are stable while out_valid&&!out_ready.
- Non-multicast addresses (lk_is_mc=0) are handled the same way using the returned mask (port 0). out_mc=0.
- Reset, including mid-operation: abort immediately; state=IDLE; no done or drop is emitted.

## Timing
- Reset values: lk_valid, out_valid, out_last, done, drop = 0. All latched fields and masks = 0. cmd_ready=1 as soon as rst_n rises.
- Accept at cycle T; lk_valid high at T+1. With lk_ready=1, lk_result_valid arrives at T+2 and the first out_valid at T+3.
- With out_ready held high: one beat per cycle. N members finish by T+2+N; done is high at T+3+N, which is the same cycle cmd_ready returns to 1.
- Drop: pulse at T+3; cmd_ready=1 at T+3.
- lk_ready low: hold lk_valid and lk_addr until accepted.
- cmd_ready stays low from T+1 until return to IDLE. No command overlap.

## Structure
- tswitch_pkg: add the mc_fanout_state_t enum (IDLE, REQ, WAIT, SEND). ADDR_WIDTH, DATA_WIDTH and GROUP_ID_BITS already live there.
- Sub-module prio_enc_lsb #(W): combinational lowest-set-bit index plus one-hot, used for out_port and the bit clear.
- Done and drop are registered pulses. The remaining mask is a NUM_PORTS register.

## Test plan
- Default table, addr 0x1000_0040, src=2, EXCLUDE_SRC=1, out_ready=1: beats to ports 0,1,3; out_last only on port 3; out_group_id=0; out_mc=1; done at T+6.
- addr 0x3000_0000, src=0, out_ready toggling 0/1: beats to ports 2 then 3; all out_* stable across stall cycles; done one cycle after the port-3 handshake.
- addr 0x2000_0000, src=0: single beat to port 1 with out_last=1 and group_id=1.
- addr 0x0000_1000, src=0: mask 0001 minus src = 0, so drop pulses at T+3; out_valid never rises; cmd_ready=1 at T+3.
- rst_n low during SEND after the first beat: all outputs reach reset values asynchronously; no done or drop. After rst_n rises, the next command (addr 0x1000_0000, src=3) delivers ports 0,1,2 correctly.
- cmd_valid held high with two queued commands and lk_ready low for 3 cycles: lk_valid and lk_addr are held; cmd_ready stays low until done; the second command is accepted in the done cycle.
